// File: rtl/dlatch_if.sv
// Signal bundle for the clocked D-latch emulation: enable/data in, latched state out.
interface dlatch_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             changed;
  logic [CNT_W-1:0] hold_cnt;

  modport master (output en, d, input q, valid, changed, hold_cnt);
  modport slave  (input en, d, output q, valid, changed, hold_cnt);
endinterface

// File: rtl/dlatch.sv
// Clock-synchronous emulation of a transparent D latch, with capture-valid,
// change-pulse and saturating hold-cycle counter. q is always a register output.
module dlatch #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  dlatch_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_changed;
  logic [CNT_W-1:0] r_hold_cnt;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of r_q; blocking here would compare d against the new q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      r_valid    <= 1'b0;
      r_changed  <= 1'b0;
      r_hold_cnt <= '0;
    end else if (bus.en) begin
      r_q        <= bus.d;
      r_valid    <= 1'b1;
      r_changed  <= (bus.d != r_q);
      r_hold_cnt <= '0;
    end else begin
      // Holding: d is ignored entirely, so X/Z on d cannot reach q.
      r_changed <= 1'b0;
      if (r_hold_cnt != '1)
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign bus.q        = r_q;
  assign bus.valid    = r_valid;
  assign bus.changed  = r_changed;
  assign bus.hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_dlatch.sv
// Directed bench for dlatch: a default instance (CNT_W=8) and a CNT_W=2 instance
// for saturation, both driven from the same en/d stimulus.
module tb_dlatch;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [0:0] d;

  int vectors = 0;
  int errors  = 0;

  dlatch_if #(.WIDTH(1), .CNT_W(8)) bus_a ();
  dlatch_if #(.WIDTH(1), .CNT_W(2)) bus_b ();

  assign bus_a.en = en;
  assign bus_a.d  = d;
  assign bus_b.en = en;
  assign bus_b.d  = d;

  dlatch #(.WIDTH(1), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dlatch #(.WIDTH(1), .CNT_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the default instance: {q, valid, changed, hold_cnt[7:0]}.
  function automatic logic [10:0] obs_a();
    return {bus_a.q, bus_a.valid, bus_a.changed, bus_a.hold_cnt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; d = 1'b1;
    step();
    vectors++;
    if (obs_a() !== 11'b0_0_0_00000000) begin
      errors++;
      $display("FAIL reset_held: got q/v/c/cnt=%b want %b", obs_a(), 11'b0);
    end
    en = 1'b0; d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (obs_a() !== {3'b000, 8'(i)}) begin
        errors++;
        $display("FAIL reset_count%0d: got q/v/c/cnt=%b want %b", i, obs_a(), {3'b000, 8'(i)});
      end
    end
  endtask

  task automatic test_capture();
    logic [0:0] pat [3] = '{1'b1, 1'b0, 1'b1};
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = pat[i];
      step();
      vectors++;
      if (obs_a() !== {pat[i], 2'b11, 8'd0}) begin
        errors++;
        $display("FAIL capture%0d: got q/v/c/cnt=%b want %b", i, obs_a(), {pat[i], 2'b11, 8'd0});
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b0; d = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (obs_a() !== {3'b110, 8'(i)}) begin
        errors++;
        $display("FAIL hold%0d: got q/v/c/cnt=%b want %b", i, obs_a(), {3'b110, 8'(i)});
      end
    end
  endtask

  task automatic test_x_hold();
    d = 1'bx;
    step();
    vectors++;
    if (obs_a() !== {3'b110, 8'd6}) begin
      errors++;
      $display("FAIL x_hold: got q/v/c/cnt=%b want %b", obs_a(), {3'b110, 8'd6});
    end
    d = 1'bz;
    step();
    vectors++;
    if (obs_a() !== {3'b110, 8'd7}) begin
      errors++;
      $display("FAIL z_hold: got q/v/c/cnt=%b want %b", obs_a(), {3'b110, 8'd7});
    end
  endtask

  task automatic test_reenable();
    en = 1'b1; d = 1'b0;
    step();
    vectors++;
    if (obs_a() !== {3'b011, 8'd0}) begin
      errors++;
      $display("FAIL reenable0: got q/v/c/cnt=%b want %b", obs_a(), {3'b011, 8'd0});
    end
    d = 1'b1;
    step();
    vectors++;
    if (obs_a() !== {3'b111, 8'd0}) begin
      errors++;
      $display("FAIL reenable1: got q/v/c/cnt=%b want %b", obs_a(), {3'b111, 8'd0});
    end
  endtask

  task automatic test_toggle_en();
    d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 1);
      step();
      vectors++;
      if (obs_a() !== {3'b110, (i % 2 == 1) ? 8'd0 : 8'd1}) begin
        errors++;
        $display("FAIL toggle_en%0d: got q/v/c/cnt=%b want %b", i, obs_a(),
                 {3'b110, (i % 2 == 1) ? 8'd0 : 8'd1});
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (bus_b.hold_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL saturate%0d: got hold_cnt=%0d want %0d", i, bus_b.hold_cnt, exp_cnt[i]);
      end
    end
  endtask

  task automatic pulse_reset_midcycle(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_a() !== 11'b0 || bus_b.hold_cnt !== 2'd0) begin
      errors++;
      $display("FAIL %s_async: got q/v/c/cnt=%b cnt_b=%0d want %b cnt_b=0", tag, obs_a(),
               bus_b.hold_cnt, 11'b0);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    pulse_reset_midcycle("midrun");
    en = 1'b1; d = 1'b1;
    step();
    vectors++;
    if (obs_a() !== {3'b111, 8'd0}) begin
      errors++;
      $display("FAIL after_reset: got q/v/c/cnt=%b want %b", obs_a(), {3'b111, 8'd0});
    end
  endtask

  task automatic test_first_capture_zero();
    pulse_reset_midcycle("first0");
    en = 1'b1; d = 1'b0;
    step();
    vectors++;
    if (obs_a() !== {3'b010, 8'd0}) begin
      errors++;
      $display("FAIL first_zero: got q/v/c/cnt=%b want %b", obs_a(), {3'b010, 8'd0});
    end
    en = 1'b0; d = 1'b1;
    step();
    vectors++;
    if (obs_a() !== {3'b010, 8'd1}) begin
      errors++;
      $display("FAIL d_while_hold: got q/v/c/cnt=%b want %b", obs_a(), {3'b010, 8'd1});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d     = 1'b0;
    #2;
    vectors++;
    if (obs_a() !== 11'b0) begin
      errors++;
      $display("FAIL reset_initial: got q/v/c/cnt=%b want %b", obs_a(), 11'b0);
    end
    test_reset();
    test_capture();
    test_hold();
    test_x_hold();
    test_reenable();
    test_toggle_en();
    test_saturation();
    test_async_reset();
    test_first_capture_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dlatch.md
DLATCH -- requirements
Module: dlatch

Interface
REQ-001 Parameter WIDTH, default 1: data width of d and q.
REQ-002 Parameter CNT_W, default 8: width of the hold_cnt counter.
REQ-003 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port en, input, 1: latch enable; 1 = transparent/capture, 0 = hold.
REQ-006 Port d, input, WIDTH: data to be latched.
REQ-007 Port q, output, WIDTH: latched data.
REQ-008 Port valid, output, 1: high once at least one capture has occurred since reset.
REQ-009 Port changed, output, 1: one-cycle pulse when a capture alters q.
REQ-010 Port hold_cnt, output, CNT_W: consecutive cycles q has been held with en=0, saturating.

Function
REQ-011 The block SHALL be a clock-synchronous emulation of a transparent D latch; no combinational path from d to q.
REQ-012 On a rising clk edge with rst_n=1 and en=1, q SHALL load d (latency one clock edge).
REQ-013 On a rising clk edge with rst_n=1 and en=0, q SHALL retain its value regardless of d.
REQ-014 valid SHALL set to 1 on the first edge with en=1 after reset and stay 1 until the next reset.
REQ-015 changed SHALL be 1 for exactly the cycle following an edge where en=1 and d differs from the prior q; otherwise 0.
REQ-016 The first capture after reset SHALL assert changed only if d differs from the reset value 0.
REQ-017 hold_cnt SHALL clear to 0 on every edge with en=1.
REQ-018 hold_cnt SHALL increment by 1 on every edge with en=0.
REQ-019 hold_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Any d change while en=0 SHALL have no effect on q, changed or valid.
REQ-021 Toggling en without any d change SHALL leave q unchanged and keep changed at 0.
REQ-022 X/Z on d while en=0 SHALL NOT propagate to q.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force q=0, valid=0, changed=0 and hold_cnt=0.
REQ-024 While rst_n=0, outputs SHALL hold reset values regardless of en, d and clk.
REQ-025 Reset asserted mid-operation SHALL discard the latched value; the first edge after rst_n rises SHALL behave as a normal en/d edge.
REQ-026 Reset deassertion need not be synchronized inside the block; the integrator SHALL release rst_n synchronously to clk.

Verification
REQ-027 Reset: rst_n=0 with en=0, d=0, then rst_n=1 -> q=0, valid=0, changed=0, hold_cnt counts up from 0 on each edge.
REQ-028 Capture/track: en=1, d=1, then d=0, then d=1 on successive edges -> q=1,0,1 one edge later each; changed pulses each time; valid=1; hold_cnt=0.
REQ-029 Hold: q=1, then en=0, d=0 for 5 edges -> q stays 1, changed=0, hold_cnt=1..5.
REQ-030 Re-enable: after hold, en=1, d=0 then d=1 -> q=0 then q=1; hold_cnt returns to 0; changed pulses twice.
REQ-031 Saturation: CNT_W=2, en=0 for 6 edges -> hold_cnt sequence 1,2,3,3,3,3.
REQ-032 Async reset mid-run: q=1, valid=1, rst_n pulsed low between clock edges -> all outputs 0 before the next edge; after release, en=1, d=1 -> q=1, changed=1.
